serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_pkg.sv | 14 +
 rtl/serial_adder_ctrl_if.sv | 31 +++
 rtl/serial_adder_ctrl_fa_bit_cell.sv | 15 +
 rtl/serial_adder_ctrl.sv | 119 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and constants for the bit-serial adder.
//   state_t       - controller FSM encoding (IDLE / RUN / DONE)
//   WIDTH_DEFAULT - default operand/result width
package serial_adder_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: request/result bundle of the bit-serial adder.
//   start, sub, a, b, carry_in         - request side (driven by master)
//   busy, done, sum, carry_out, overflow - status/result side (driven by slave)
interface serial_adder_ctrl_if
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
);

    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    modport master (
        output start, sub, a, b, carry_in,
        input  busy, done, sum, carry_out, overflow
    );

    modport slave (
        input  start, sub, a, b, carry_in,
        output busy, done, sum, carry_out, overflow
    );

endinterface

// File: rtl/serial_adder_ctrl_fa_bit_cell.sv
// fa_bit_cell: combinational 1-bit full adder.
//   a, b, cin - addend bits and carry in
//   s, cout   - sum bit and carry out
module fa_bit_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add/subtract, LSB first, one bit per clock
// through a single full-adder cell.
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - slave side of serial_adder_ctrl_if (start/sub/a/b/carry_in in,
//           busy/done/sum/carry_out/overflow out)
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_adder_ctrl_if.slave  bus
);

    localparam int unsigned    CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic             fa_s;
    logic             fa_cout;
    logic             last_bit;
    logic             accept;

    fa_bit_cell u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign last_bit = (cnt == LAST);
    assign accept   = (state == IDLE) && bus.start;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_bit)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Only the WIDTH-1 bits already produced need storage; the final bit is
    // merged combinationally so the complete result can be latched on the
    // same edge that leaves RUN.
    if (WIDTH == 1) begin : g_res_w1
        assign res_next = fa_s;
    end else begin : g_res_wn
        logic [WIDTH-2:0] res_hi;

        always_ff @(posedge clk) begin
            if (!rst_n || accept) begin
                res_hi <= '0;
            end else if (state == RUN) begin
                res_hi <= res_next[WIDTH-1:1];
            end
        end

        assign res_next = {fa_s, res_hi};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            cnt     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_sr    <= bus.a;
            // Subtraction as a + ~b + 1: invert b and force the carry seed.
            b_sr    <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub ? 1'b1 : bus.carry_in;
            cnt     <= '0;
        end else if (state == RUN) begin
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            carry_q <= fa_cout;
            if (last_bit) begin
                sum_q  <= res_next;
                cout_q <= fa_cout;
                // carry_q is the carry into the MSB on the final bit.
                ovf_q  <= carry_q ^ fa_cout;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign bus.busy      = (state == RUN);
    assign bus.done      = (state == DONE);
    assign bus.sum       = sum_q;
    assign bus.carry_out = cout_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed, table-driven bench for serial_adder_ctrl
// (WIDTH=8 instance plus a WIDTH=1 instance).
module tb_serial_adder_ctrl;
    import serial_adder_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_adder_ctrl_if #(.WIDTH(8)) m8 ();
    serial_adder_ctrl_if #(.WIDTH(1)) m1 ();

    serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(m8));
    serial_adder_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(m1));

    typedef struct {
        logic       sub;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs [9];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Issue one 8-bit op, scramble the inputs right after acceptance, then
    // check latency, busy length, result and the hold after the done pulse.
    task automatic run8(input vec_t v, input string tag);
        int cyc;
        int nbusy;
        bit seen;
        @(negedge clk);
        m8.sub = v.sub; m8.a = v.a; m8.b = v.b; m8.carry_in = v.cin; m8.start = 1'b1;
        @(negedge clk);
        m8.start = 1'b0; m8.a = ~v.a; m8.b = 8'h5A; m8.carry_in = ~v.cin; m8.sub = ~v.sub;
        cyc = 1; nbusy = 0; seen = 1'b0;
        while (cyc < 40) begin
            if (m8.done) begin
                seen = 1'b1;
                break;
            end
            if (m8.busy) nbusy++;
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done_cycle"}, seen ? cyc : 0, 9);
        chk({tag, "_busy_cycles"}, nbusy, 8);
        chk({tag, "_sum"}, m8.sum, v.sum);
        chk({tag, "_cout"}, m8.carry_out, v.cout);
        chk({tag, "_ovf"}, m8.overflow, v.ovf);
        @(negedge clk);
        chk({tag, "_done_single"}, m8.done, 1'b0);
        chk({tag, "_sum_held"}, m8.sum, v.sum);
    endtask

    task automatic run1(input logic s, input logic a, input logic b, input logic ci,
                        input logic es, input logic ec, input logic eo, input string tag);
        int cyc;
        bit seen;
        @(negedge clk);
        m1.sub = s; m1.a = a; m1.b = b; m1.carry_in = ci; m1.start = 1'b1;
        @(negedge clk);
        m1.start = 1'b0; m1.a = ~a; m1.b = ~b;
        cyc = 1; seen = 1'b0;
        while (cyc < 20) begin
            if (m1.done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done_cycle"}, seen ? cyc : 0, 2);
        chk({tag, "_sum"}, m1.sum, es);
        chk({tag, "_cout"}, m1.carry_out, ec);
        chk({tag, "_ovf"}, m1.overflow, eo);
    endtask

    initial begin
        int ndone;

        vecs[0] = '{1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};

        // Reset with start held high: must stay idle.
        m8.start = 1'b1; m8.sub = 1'b0; m8.a = 8'hFF; m8.b = 8'hFF; m8.carry_in = 1'b1;
        m1.start = 1'b1; m1.sub = 1'b0; m1.a = 1'b1; m1.b = 1'b1; m1.carry_in = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", m8.busy, 1'b0);
        chk("rst_done", m8.done, 1'b0);
        chk("rst_sum", m8.sum, 8'h00);
        chk("rst_cout", m8.carry_out, 1'b0);
        chk("rst_ovf", m8.overflow, 1'b0);
        chk("rst_busy_w1", m1.busy, 1'b0);
        rst_n = 1'b1; m8.start = 1'b0; m1.start = 1'b0;
        @(negedge clk);
        chk("start_in_reset_ignored", m8.busy, 1'b0);

        for (int i = 0; i < 9; i++) begin
            run8(vecs[i], $sformatf("v%0d", i));
        end

        // Start pulsed mid-run with different operands: ignored, not queued.
        @(negedge clk);
        m8.sub = 1'b0; m8.a = 8'h0F; m8.b = 8'h01; m8.carry_in = 1'b0; m8.start = 1'b1;
        @(negedge clk);
        m8.start = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 15; c++) begin
            if (c == 3) begin
                m8.start = 1'b1; m8.a = 8'hFF; m8.b = 8'hFF; m8.carry_in = 1'b1;
            end
            if (c == 4) m8.start = 1'b0;
            if (m8.done) ndone++;
            @(negedge clk);
        end
        chk("midrun_start_done_count", ndone, 1);
        chk("midrun_start_sum", m8.sum, 8'h10);
        chk("midrun_start_not_queued", m8.busy, 1'b0);

        // Reset at RUN cycle 4 aborts and clears the previous result.
        m8.sub = 1'b0; m8.a = 8'h12; m8.b = 8'h34; m8.carry_in = 1'b0; m8.start = 1'b1;
        @(negedge clk);
        m8.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_abort_busy", m8.busy, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", m8.busy, 1'b0);
        chk("abort_done", m8.done, 1'b0);
        chk("abort_sum", m8.sum, 8'h00);
        chk("abort_cout", m8.carry_out, 1'b0);
        chk("abort_ovf", m8.overflow, 1'b0);
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            if (m8.done) ndone++;
            @(negedge clk);
        end
        chk("abort_no_done", ndone, 0);
        run8('{1'b0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0}, "after_abort");

        // WIDTH=1 build.
        run1(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "w1_add");
        run1(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "w1_sub");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
